// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: FSM state encodings,
// the RATE_SEL width and the default cycle counts for the 27 MHz board clock.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } btn_state_t;

  localparam int RATE_W          = 2;
  localparam int DEF_DB_CYCLES   = 270_000;     // 10 ms at 27 MHz
  localparam int DEF_LONG_CYCLES = 27_000_000;  // 1 s at 27 MHz

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an asynchronous board input. RST_VAL sets the
// level both flops take during reset so the downstream logic sees an idle input.
module btn_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic sync_p0;
  logic sync_p1;

  // Two-stage metastability filter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= D;
      sync_p1 <= sync_p0;
    end
  end

  assign Q = sync_p1;

endmodule

// File: rtl/button_debounce.sv
// Push-button front end for the LED blinker: synchronizes and debounces the
// raw button, classifies presses as short or long and keeps the 2-bit blink
// rate selection. Long-press detection is built only when the macro
// BUTTON_DEBOUNCE_LONG_PRESS_EN is defined; otherwise every accepted release
// is a short press and LONG_P is tied low.
module button_debounce
  import btn_pkg::*;
#(
  parameter int DB_CYCLES      = DEF_DB_CYCLES,
  parameter int LONG_CYCLES    = DEF_LONG_CYCLES,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BTN_IN,
  output logic              BTN_STATE,
  output logic              PRESS_P,
  output logic              SHORT_P,
  output logic              LONG_P,
  output logic [RATE_W-1:0] RATE_SEL
);

  localparam int               CNT_W        = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DB_CYCLES - 1);
  localparam logic             RELEASED_LVL = BTN_ACTIVE_LOW;

  if (DB_CYCLES < 2) begin : g_bad_db
    $error("button_debounce: DB_CYCLES must be at least 2");
  end
  if (LONG_CYCLES <= DB_CYCLES) begin : g_bad_long
    $error("button_debounce: LONG_CYCLES must exceed DB_CYCLES");
  end

  logic             btn_s;
  logic             act;
  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] db_cnt, db_cnt_nxt;
  logic             press_nxt;
  logic             rel_acc;
  logic             short_nxt;

  btn_sync #(
    .RST_VAL (RELEASED_LVL)
  ) u_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (BTN_IN),
    .Q   (btn_s)
  );

  // Normalise polarity so act = 1 always means pressed.
  assign act       = btn_s ^ RELEASED_LVL;
  assign BTN_STATE = (state == HELD) || (state == DB_RELEASE);

  // State register, debounce counter and the registered press/short pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      db_cnt  <= '0;
      PRESS_P <= 1'b0;
      SHORT_P <= 1'b0;
    end else begin
      state   <= state_nxt;
      db_cnt  <= db_cnt_nxt;
      PRESS_P <= press_nxt;
      SHORT_P <= short_nxt;
    end
  end

  // Debounce FSM: the cycle that leaves IDLE/HELD counts as the first stable
  // sample, so acceptance happens when the counter would reach DB_CYCLES.
  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    press_nxt  = 1'b0;
    rel_acc    = 1'b0;
    case (state)
      IDLE: begin
        if (act) begin
          state_nxt  = DB_PRESS;
          db_cnt_nxt = CNT_W'(1);
        end
      end
      DB_PRESS: begin
        if (!act) begin
          state_nxt  = IDLE;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = HELD;
          db_cnt_nxt = '0;
          press_nxt  = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!act) begin
          state_nxt  = DB_RELEASE;
          db_cnt_nxt = CNT_W'(1);
        end
      end
      DB_RELEASE: begin
        if (act) begin
          state_nxt  = HELD;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = IDLE;
          db_cnt_nxt = '0;
          rel_acc    = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        db_cnt_nxt = '0;
      end
    endcase
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int                LONG_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] long_cnt;
  logic              long_done;
  logic              long_hit;

  // Expiry is checked before the release outcome so a simultaneous release
  // is reported as long, not short.
  assign long_hit  = BTN_STATE && !long_done && (long_cnt == LONG_LAST);
  assign short_nxt = rel_acc && !long_done && !long_hit;

  // Hold timer: restarts on each accepted press, runs through release
  // bounces and stops once the long press has been flagged.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      long_cnt  <= '0;
      long_done <= 1'b0;
      LONG_P    <= 1'b0;
    end else begin
      LONG_P <= long_hit;
      if (press_nxt) begin
        long_cnt  <= '0;
        long_done <= 1'b0;
      end else if (BTN_STATE && !long_done) begin
        long_cnt <= long_cnt + LONG_W'(1);
        if (long_hit) begin
          long_done <= 1'b1;
        end
      end
    end
  end
`else
  assign short_nxt = rel_acc;
  assign LONG_P    = 1'b0;
`endif

  // Blink-rate index: step on a short press, clear on a long press.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RATE_SEL <= '0;
    end else if (LONG_P) begin
      RATE_SEL <= '0;
    end else if (SHORT_P) begin
      RATE_SEL <= RATE_SEL + RATE_W'(1);
    end
  end

endmodule
